// File: rtl/mips_pkg.sv
// Shared types and constants for the 5-stage MIPS core control logic.
// Holds the hazard controller FSM state encoding and a register-match helper.
package mips_pkg;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StHalted
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // r0 is hard-wired to zero, so a write to it never creates a dependency.
  function automatic logic reg_match(
    input logic [4:0] r,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rs,
    input logic       uses_rt
  );
    return (r != REG_ZERO) && ((uses_rs && (r == rs)) || (uses_rt && (r == rt)));
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use and branch-operand hazard detection for the ID stage.
// Produces the raw stall request; the caller decides when it applies.
module hazard_detect
  import mips_pkg::*;
(
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       uses_rs,
  input  logic       uses_rt,
  input  logic       id_branch,
  input  logic       idex_mem_read,
  input  logic       idex_reg_write,
  input  logic [4:0] idex_wr_reg,
  input  logic       exmem_mem_read,
  input  logic [4:0] exmem_wr_reg,
  output logic       load_use,
  output logic       br_haz,
  output logic       stall
);

  logic ex_match;
  logic mem_match;

  always_comb begin
    ex_match  = reg_match(idex_wr_reg, ifid_rs, ifid_rt, uses_rs, uses_rt);
    mem_match = reg_match(exmem_wr_reg, ifid_rs, ifid_rt, uses_rs, uses_rt);
    load_use  = idex_mem_read && ex_match;
    // Branches resolve in ID, so an ALU result still in EX or a load still in MEM is too late.
    br_haz    = id_branch && ((idex_reg_write && ex_match) || (exmem_mem_read && mem_match));
    stall     = load_use || br_haz;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and halt controller: stall/flush control, HALT drain sequencing
// and a saturating hazard-stall counter. State updates on the falling clock edge.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DRAIN_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       i_IFID_rs,
  input  logic [4:0]       i_IFID_rt,
  input  logic             i_Uses_rs,
  input  logic             i_Uses_rt,
  input  logic             i_ID_Branch,
  input  logic             i_Take_Branch,
  input  logic             i_ID_Halt,
  input  logic             i_IDEX_MemRead,
  input  logic             i_IDEX_RegWrite,
  input  logic [4:0]       i_IDEX_WrReg,
  input  logic             i_EXMEM_MemRead,
  input  logic [4:0]       i_EXMEM_WrReg,
  input  logic             i_WB_Halt,
  output logic             o_PC_Write,
  output logic             o_IFID_Write,
  output logic             o_IFID_Flush,
  output logic             o_IDEX_Stall,
  output logic             o_Halted,
  output logic             o_Drain_Err,
  output logic [CNT_W-1:0] o_Stall_Count
);

  localparam int unsigned       DrainW    = $clog2(DRAIN_MAX + 1);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_MAX - 1);
  localparam logic [CNT_W-1:0]  CntMax    = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              drain_err_q, drain_err_d;

  logic load_use;
  logic br_haz;
  logic haz_stall;

  hazard_detect u_hazard_detect (
    .ifid_rs       (i_IFID_rs),
    .ifid_rt       (i_IFID_rt),
    .uses_rs       (i_Uses_rs),
    .uses_rt       (i_Uses_rt),
    .id_branch     (i_ID_Branch),
    .idex_mem_read (i_IDEX_MemRead),
    .idex_reg_write(i_IDEX_RegWrite),
    .idex_wr_reg   (i_IDEX_WrReg),
    .exmem_mem_read(i_EXMEM_MemRead),
    .exmem_wr_reg  (i_EXMEM_WrReg),
    .load_use      (load_use),
    .br_haz        (br_haz),
    .stall         (haz_stall)
  );

  always_comb begin
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    drain_err_d  = drain_err_q;
    o_PC_Write   = 1'b0;
    o_IFID_Write = 1'b0;
    o_IFID_Flush = 1'b0;
    o_IDEX_Stall = 1'b0;

    unique case (state_q)
      StRun: begin
        if (haz_stall) begin
          o_IDEX_Stall = 1'b1;
          if (stall_cnt_q != CntMax) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
        end else if (i_ID_Halt) begin
          // HALT moves on into EX; the fetched instruction behind it is squashed.
          o_IFID_Write = 1'b1;
          o_IFID_Flush = 1'b1;
          drain_cnt_d  = '0;
          state_d      = StDrain;
        end else begin
          o_PC_Write   = 1'b1;
          o_IFID_Write = 1'b1;
          o_IFID_Flush = i_Take_Branch;
        end
      end
      StDrain: begin
        o_IDEX_Stall = 1'b1;
        drain_cnt_d  = drain_cnt_q + 1'b1;
        if (i_WB_Halt) begin
          state_d = StHalted;
        end else if (drain_cnt_q == DrainLast) begin
          state_d     = StHalted;
          drain_err_d = 1'b1;
        end
      end
      StHalted: begin
        o_IDEX_Stall = 1'b1;
      end
      default: begin
        state_d = StRun;
      end
    endcase

    // Reset quiesces every pipeline enable regardless of state.
    if (rst) begin
      o_PC_Write   = 1'b0;
      o_IFID_Write = 1'b0;
      o_IFID_Flush = 1'b0;
      o_IDEX_Stall = 1'b0;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      drain_cnt_q <= '0;
      stall_cnt_q <= '0;
      drain_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      drain_err_q <= drain_err_d;
    end
  end

  assign o_Halted      = (state_q == StHalted);
  assign o_Drain_Err   = drain_err_q;
  assign o_Stall_Count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, hand sequences for HALT
// draining and counter saturation, then randomized traffic against a behavioural model.
module tb_hazard_ctrl;

  logic       clk = 1'b1;
  logic       rst;
  logic [4:0] ifid_rs, ifid_rt, ex_wr, mem_wr;
  logic       uses_rs, uses_rt, id_branch, take_branch, id_halt;
  logic       ex_mr, ex_rw, mem_mr, wb_halt;

  logic        a_pc, a_ifid, a_flush, a_bub, a_halted, a_err;
  logic [15:0] a_cnt;
  logic        b_pc, b_ifid, b_flush, b_bub, b_halted, b_err;
  logic [3:0]  b_cnt;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .i_IFID_rs(ifid_rs), .i_IFID_rt(ifid_rt),
    .i_Uses_rs(uses_rs), .i_Uses_rt(uses_rt), .i_ID_Branch(id_branch),
    .i_Take_Branch(take_branch), .i_ID_Halt(id_halt), .i_IDEX_MemRead(ex_mr),
    .i_IDEX_RegWrite(ex_rw), .i_IDEX_WrReg(ex_wr), .i_EXMEM_MemRead(mem_mr),
    .i_EXMEM_WrReg(mem_wr), .i_WB_Halt(wb_halt), .o_PC_Write(a_pc), .o_IFID_Write(a_ifid),
    .o_IFID_Flush(a_flush), .o_IDEX_Stall(a_bub), .o_Halted(a_halted),
    .o_Drain_Err(a_err), .o_Stall_Count(a_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) dut_c4 (
    .clk(clk), .rst(rst), .i_IFID_rs(ifid_rs), .i_IFID_rt(ifid_rt),
    .i_Uses_rs(uses_rs), .i_Uses_rt(uses_rt), .i_ID_Branch(id_branch),
    .i_Take_Branch(take_branch), .i_ID_Halt(id_halt), .i_IDEX_MemRead(ex_mr),
    .i_IDEX_RegWrite(ex_rw), .i_IDEX_WrReg(ex_wr), .i_EXMEM_MemRead(mem_mr),
    .i_EXMEM_WrReg(mem_wr), .i_WB_Halt(wb_halt), .o_PC_Write(b_pc), .o_IFID_Write(b_ifid),
    .o_IFID_Flush(b_flush), .o_IDEX_Stall(b_bub), .o_Halted(b_halted),
    .o_Drain_Err(b_err), .o_Stall_Count(b_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0=running, 1=draining, 2=halted.
  int m_mode, m_drain, m_total;
  bit m_err;

  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt, br, take, ex_mr, ex_rw;
    logic [4:0] ex_wr;
    logic       mem_mr;
    logic [4:0] mem_wr;
    logic       pc, ifid, fl, bub;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit mt(input logic [4:0] r);
    return (r != 0) && ((uses_rs && r == ifid_rs) || (uses_rt && r == ifid_rt));
  endfunction

  function automatic int sat(input int v, input int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic clear_in();
    ifid_rs = 0; ifid_rt = 0; uses_rs = 0; uses_rt = 0; id_branch = 0; take_branch = 0;
    id_halt = 0; ex_mr = 0; ex_rw = 0; ex_wr = 0; mem_mr = 0; mem_wr = 0; wb_halt = 0;
  endtask

  // Inputs are already driven; check outputs mid-cycle, then advance past the negedge.
  task automatic step();
    bit st;
    int e_pc, e_ifid, e_fl, e_bub;
    #2;
    st = (ex_mr && mt(ex_wr)) ||
         (id_branch && ((ex_rw && mt(ex_wr)) || (mem_mr && mt(mem_wr))));
    if (rst) begin
      e_pc = 0; e_ifid = 0; e_fl = 0; e_bub = 0;
    end else if (m_mode == 0) begin
      if (st)           begin e_pc = 0; e_ifid = 0; e_fl = 0; e_bub = 1; end
      else if (id_halt) begin e_pc = 0; e_ifid = 1; e_fl = 1; e_bub = 0; end
      else              begin e_pc = 1; e_ifid = 1; e_fl = int'(take_branch); e_bub = 0; end
    end else begin
      e_pc = 0; e_ifid = 0; e_fl = 0; e_bub = 1;
    end
    check("pc_write", a_pc, e_pc);
    check("ifid_write", a_ifid, e_ifid);
    check("ifid_flush", a_flush, e_fl);
    check("idex_stall", a_bub, e_bub);
    check("halted", a_halted, int'(m_mode == 2));
    check("drain_err", a_err, int'(m_err));
    check("stall_count", a_cnt, sat(m_total, 16));
    check("c4_pc_write", b_pc, e_pc);
    check("c4_idex_stall", b_bub, e_bub);
    check("c4_halted", b_halted, int'(m_mode == 2));
    check("c4_stall_count", b_cnt, sat(m_total, 4));
    @(negedge clk);
    if (rst) begin
      m_mode = 0; m_drain = 0; m_err = 0; m_total = 0;
    end else if (m_mode == 0) begin
      if (st) m_total++;
      else if (id_halt) begin m_mode = 1; m_drain = 0; end
    end else if (m_mode == 1) begin
      m_drain++;
      if (wb_halt) m_mode = 2;
      else if (m_drain == 8) begin m_mode = 2; m_err = 1; end
    end
    #1;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1;
    step();
    rst = 0;
  endtask

  initial begin
    vecs[0]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0};

    clear_in();
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    m_mode = 0; m_drain = 0; m_err = 0; m_total = 0;
    do_reset();

    // Load into r5 in EX, ID reads r5: one stall, then normal.
    ex_mr = 1; ex_rw = 1; ex_wr = 5; ifid_rs = 5; uses_rs = 1;
    step();
    clear_in();
    step();
    check("t1_count", a_cnt, 1);

    // Branch operand in EX (ALU), then in MEM (load).
    do_reset();
    id_branch = 1; ifid_rs = 3; ifid_rt = 4; uses_rs = 1; uses_rt = 1; ex_rw = 1; ex_wr = 4;
    step();
    ex_rw = 0; ex_wr = 0; mem_mr = 1; mem_wr = 4;
    step();
    clear_in();
    step();
    check("t2_count", a_cnt, 2);

    // Taken jump: a single flush cycle.
    take_branch = 1;
    step();
    clear_in();
    step();
    check("t3_flush_after", a_flush, 0);

    // Vector table from a clean RUN state.
    do_reset();
    foreach (vecs[i]) begin
      clear_in();
      ifid_rs = vecs[i].rs; ifid_rt = vecs[i].rt; uses_rs = vecs[i].urs; uses_rt = vecs[i].urt;
      id_branch = vecs[i].br; take_branch = vecs[i].take; ex_mr = vecs[i].ex_mr;
      ex_rw = vecs[i].ex_rw; ex_wr = vecs[i].ex_wr; mem_mr = vecs[i].mem_mr;
      mem_wr = vecs[i].mem_wr;
      #1;
      check($sformatf("vec%0d_pc", i), a_pc, vecs[i].pc);
      check($sformatf("vec%0d_ifid", i), a_ifid, vecs[i].ifid);
      check($sformatf("vec%0d_flush", i), a_flush, vecs[i].fl);
      check($sformatf("vec%0d_bubble", i), a_bub, vecs[i].bub);
      step();
    end
    clear_in();
    step();
    check("vec_count", a_cnt, 5);

    // WB_Halt while running is ignored.
    wb_halt = 1;
    repeat (2) step();
    check("wb_in_run_halted", a_halted, 0);
    check("wb_in_run_pc", a_pc, 1);

    // HALT, WB_Halt arrives on the third drain cycle.
    do_reset();
    id_halt = 1;
    step();
    clear_in();
    repeat (2) step();
    wb_halt = 1;
    step();
    clear_in();
    check("t5_halted", a_halted, 1);
    check("t5_err", a_err, 0);
    step();

    // HALT without WB_Halt: drain timeout after 8 cycles.
    do_reset();
    id_halt = 1;
    step();
    clear_in();
    repeat (7) step();
    check("t6_not_yet", a_halted, 0);
    step();
    check("t6_halted", a_halted, 1);
    check("t6_err", a_err, 1);
    id_halt = 1;
    step();
    clear_in();

    // Reset in the middle of a drain.
    do_reset();
    id_halt = 1;
    step();
    clear_in();
    repeat (3) step();
    do_reset();
    check("mid_rst_halted", a_halted, 0);
    check("mid_rst_err", a_err, 0);
    step();

    // Saturation of the narrow counter.
    do_reset();
    ex_mr = 1; ex_wr = 9; ifid_rt = 9; uses_rt = 1;
    repeat (20) step();
    clear_in();
    step();
    check("sat_c4", b_cnt, 15);
    check("sat_c16", a_cnt, 20);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 199) == 0);
      ifid_rs     = 5'($urandom_range(0, 3));
      ifid_rt     = 5'($urandom_range(0, 3));
      ex_wr       = 5'($urandom_range(0, 3));
      mem_wr      = 5'($urandom_range(0, 3));
      uses_rs     = 1'($urandom);
      uses_rt     = 1'($urandom);
      id_branch   = 1'($urandom);
      take_branch = 1'($urandom);
      ex_mr       = ($urandom_range(0, 3) == 0);
      ex_rw       = 1'($urandom);
      mem_mr      = ($urandom_range(0, 3) == 0);
      id_halt     = ($urandom_range(0, 29) == 0);
      wb_halt     = ($urandom_range(0, 9) == 0);
      step();
    end
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
